// File: rtl/ultra_pkg.sv
// rtl/ultra_pkg.sv - shared FSM encodings and delay constants for the receive datapath
package ultra_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

    // Defaults shared with sample_delay so both ends agree on delay width/limit
    localparam int         ULTRA_DELAY_W   = 8;
    localparam logic [7:0] ULTRA_MAX_DELAY = 8'd200;

endpackage

// File: rtl/delay_table.sv
// rtl/delay_table.sv - per-zone, per-channel delay register array with saturating write
module delay_table
    import ultra_pkg::*;
#(
    parameter int                 NUM_ZONES = 4,
    parameter int                 NUM_CH    = 4,
    parameter int                 DELAY_W   = ULTRA_DELAY_W,
    parameter logic [DELAY_W-1:0] MAX_DELAY = ULTRA_MAX_DELAY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_ZONES)-1:0]  wr_zone,
    input  logic [$clog2(NUM_CH)-1:0]     wr_ch,
    input  logic [DELAY_W-1:0]            wr_delay,
    input  logic [$clog2(NUM_ZONES)-1:0]  rd_zone,
    output logic [NUM_CH*DELAY_W-1:0]     rd_row
);

    logic [DELAY_W-1:0] mem_q [NUM_ZONES][NUM_CH];
    logic [DELAY_W-1:0] mem_d [NUM_ZONES][NUM_CH];
    logic [DELAY_W-1:0] wr_sat;

    // Clamp incoming values and apply the single write port
    always_comb begin
        mem_d  = mem_q;
        wr_sat = (wr_delay > MAX_DELAY) ? MAX_DELAY : wr_delay;
        if (wr_en) begin
            mem_d[wr_zone][wr_ch] = wr_sat;
        end
    end

    // Table storage, cleared to zero on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    mem_q[z][c] <= '0;
                end
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Combinational row read, channel 0 in the LSBs
    always_comb begin
        rd_row = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_row[c*DELAY_W +: DELAY_W] = mem_q[rd_zone][c];
        end
    end

endmodule

// File: rtl/us_delay_sched.sv
// rtl/us_delay_sched.sv - zone/line sequencer driving dynamically focused sample_delay values
module us_delay_sched
    import ultra_pkg::*;
#(
    parameter int                 NUM_CH       = 4,
    parameter int                 DELAY_W      = ULTRA_DELAY_W,
    parameter logic [DELAY_W-1:0] MAX_DELAY    = ULTRA_MAX_DELAY,
    parameter int                 NUM_ZONES    = 4,
    parameter int                 ZONE_SAMPLES = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    input  logic [7:0]                    num_lines,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_ZONES)-1:0]  cfg_zone,
    input  logic [$clog2(NUM_CH)-1:0]     cfg_ch,
    input  logic [DELAY_W-1:0]            cfg_delay,
    output logic                          cfg_err,
    output logic                          busy,
    output logic                          done,
    output logic                          sample_en,
    output logic                          delay_upd,
    output logic                          line_start,
    output logic [$clog2(NUM_ZONES)-1:0]  zone_idx,
    output logic [7:0]                    line_idx,
    output logic [NUM_CH*DELAY_W-1:0]     delay_o
);

    localparam int ZW = $clog2(NUM_ZONES);
    localparam int SW = (ZONE_SAMPLES > 1) ? $clog2(ZONE_SAMPLES) : 1;
    localparam logic [SW-1:0] LAST_SAMPLE = SW'(ZONE_SAMPLES - 1);
    localparam logic [ZW-1:0] LAST_ZONE   = ZW'(NUM_ZONES - 1);

    sched_state_t              state_q, state_d;
    logic [ZW-1:0]             zone_q, zone_d;
    logic [7:0]                line_q, line_d;
    logic [7:0]                nl_q, nl_d;
    logic [SW-1:0]             cnt_q, cnt_d;
    logic [NUM_CH*DELAY_W-1:0] delay_q, delay_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      sample_en_q, sample_en_d;
    logic                      delay_upd_q, delay_upd_d;
    logic                      line_start_q, line_start_d;
    logic                      cfg_err_q, cfg_err_d;
    logic [NUM_CH*DELAY_W-1:0] row_rd;
    logic                      tbl_we;

    // The table is only writable while no scan is walking it
    assign tbl_we = cfg_we && !busy_q;

    delay_table #(
        .NUM_ZONES (NUM_ZONES),
        .NUM_CH    (NUM_CH),
        .DELAY_W   (DELAY_W),
        .MAX_DELAY (MAX_DELAY)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (tbl_we),
        .wr_zone  (cfg_zone),
        .wr_ch    (cfg_ch),
        .wr_delay (cfg_delay),
        .rd_zone  (zone_q),
        .rd_row   (row_rd)
    );

    // Next-state, counter and registered-output computation
    always_comb begin
        state_d  = state_q;
        zone_d   = zone_q;
        line_d   = line_q;
        nl_d     = nl_q;
        cnt_d    = cnt_q;
        delay_d  = delay_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nl_d    = num_lines;
                    zone_d  = '0;
                    line_d  = '0;
                    cnt_d   = '0;
                    state_d = (num_lines == 8'd0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                delay_d = row_rd;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == LAST_SAMPLE) begin
                    cnt_d = '0;
                    if (zone_q != LAST_ZONE) begin
                        zone_d  = zone_q + ZW'(1);
                        state_d = ST_LOAD;
                    end else if (line_q != nl_q - 8'd1) begin
                        line_d  = line_q + 8'd1;
                        zone_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + SW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort freezes position and delays so the host can see where it stopped
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            zone_d  = zone_q;
            line_d  = line_q;
            cnt_d   = cnt_q;
            delay_d = delay_q;
        end

        busy_d       = (state_d == ST_LOAD) || (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        sample_en_d  = (state_d == ST_RUN);
        delay_upd_d  = (state_q == ST_LOAD) && (state_d == ST_RUN);
        line_start_d = delay_upd_d && (zone_q == '0);
        cfg_err_d    = cfg_we && busy_q;
    end

    // State, counters and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            zone_q       <= '0;
            line_q       <= '0;
            nl_q         <= '0;
            cnt_q        <= '0;
            delay_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sample_en_q  <= 1'b0;
            delay_upd_q  <= 1'b0;
            line_start_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            zone_q       <= zone_d;
            line_q       <= line_d;
            nl_q         <= nl_d;
            cnt_q        <= cnt_d;
            delay_q      <= delay_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sample_en_q  <= sample_en_d;
            delay_upd_q  <= delay_upd_d;
            line_start_q <= line_start_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign sample_en  = sample_en_q;
    assign delay_upd  = delay_upd_q;
    assign line_start = line_start_q;
    assign cfg_err    = cfg_err_q;
    assign zone_idx   = zone_q;
    assign line_idx   = line_q;
    assign delay_o    = delay_q;

endmodule

// File: tb/tb_us_delay_sched.sv
// tb/tb_us_delay_sched.sv - directed self-checking bench for us_delay_sched
module tb_us_delay_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  num_lines = 8'd0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_zone = 2'd0;
    logic [1:0]  cfg_ch = 2'd0;
    logic [7:0]  cfg_delay = 8'd0;
    logic        cfg_err, busy, done, sample_en, delay_upd, line_start;
    logic [1:0]  zone_idx;
    logic [7:0]  line_idx;
    logic [31:0] delay_o;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] zone_dly [4];
    int          unstable;
    logic [3:0]  f1, f2;

    us_delay_sched dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .num_lines  (num_lines),
        .cfg_we     (cfg_we),
        .cfg_zone   (cfg_zone),
        .cfg_ch     (cfg_ch),
        .cfg_delay  (cfg_delay),
        .cfg_err    (cfg_err),
        .busy       (busy),
        .done       (done),
        .sample_en  (sample_en),
        .delay_upd  (delay_upd),
        .line_start (line_start),
        .zone_idx   (zone_idx),
        .line_idx   (line_idx),
        .delay_o    (delay_o)
    );

    always #5 clk = ~clk;

    task automatic wr(input int z, input int c, input int d);
        cfg_we = 1'b1; cfg_zone = 2'(z); cfg_ch = 2'(c); cfg_delay = 8'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Runs one scan from start to done, collecting counts; n counts negedges after start
    task automatic do_scan(input logic [7:0] nl, output int done_n, output int sen,
                           output int upd, output int ls, output int both);
        int bound;
        bound = 8 + int'(nl) * 4 * 65;
        done_n = 0; sen = 0; upd = 0; ls = 0; both = 0; unstable = 0;
        f1 = 4'h0; f2 = 4'h0;
        start = 1'b1; num_lines = nl;
        for (int n = 1; n <= bound && done_n == 0; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 1) f1 = {busy, sample_en, delay_upd, line_start};
            if (n == 2) f2 = {busy, sample_en, delay_upd, line_start};
            if (sample_en) sen++;
            if (delay_upd) begin
                upd++;
                zone_dly[zone_idx] = delay_o;
            end else if (sample_en && delay_o != zone_dly[zone_idx]) begin
                unstable++;
            end
            if (line_start) ls++;
            if (done && busy) both++;
            if (done) done_n = n;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({busy, done, sample_en, delay_upd, line_start, cfg_err} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags got %b exp 000000", {busy, done, sample_en, delay_upd, line_start, cfg_err});
        end
        tests_run++;
        if (delay_o !== 32'h0) begin
            tests_failed++; $display("FAIL reset_delay got %h exp 00000000", delay_o);
        end
        tests_run++;
        if ({zone_idx, line_idx} !== 10'h0) begin
            tests_failed++; $display("FAIL reset_idx got %h/%h exp 0/0", zone_idx, line_idx);
        end
    endtask

    task automatic test_basic_scan();
        int dn, sen, upd, ls, both;
        for (int z = 0; z < 4; z++)
            for (int c = 0; c < 4; c++)
                wr(z, c, 10 * z + c);
        do_scan(8'd2, dn, sen, upd, ls, both);
        tests_run++;
        if (dn !== 521) begin tests_failed++; $display("FAIL basic_done_latency got %0d exp 521", dn); end
        tests_run++;
        if (sen !== 512) begin tests_failed++; $display("FAIL basic_sample_en got %0d exp 512", sen); end
        tests_run++;
        if (upd !== 8) begin tests_failed++; $display("FAIL basic_delay_upd got %0d exp 8", upd); end
        tests_run++;
        if (ls !== 2) begin tests_failed++; $display("FAIL basic_line_start got %0d exp 2", ls); end
        tests_run++;
        if (both !== 0) begin tests_failed++; $display("FAIL basic_done_busy_overlap got %0d exp 0", both); end
        tests_run++;
        if (zone_dly[1] !== 32'h0D0C0B0A) begin
            tests_failed++; $display("FAIL basic_zone1_delay got %h exp 0d0c0b0a", zone_dly[1]);
        end
        tests_run++;
        if (zone_dly[3] !== 32'h21201F1E) begin
            tests_failed++; $display("FAIL basic_zone3_delay got %h exp 21201f1e", zone_dly[3]);
        end
        tests_run++;
        if (unstable !== 0) begin tests_failed++; $display("FAIL basic_delay_stable got %0d exp 0", unstable); end
        tests_run++;
        if (f1 !== 4'b1000) begin tests_failed++; $display("FAIL basic_load_cycle got %b exp 1000", f1); end
        tests_run++;
        if (f2 !== 4'b1111) begin tests_failed++; $display("FAIL basic_first_run got %b exp 1111", f2); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_saturation();
        int dn, sen, upd, ls, both;
        wr(3, 2, 255);
        do_scan(8'd1, dn, sen, upd, ls, both);
        tests_run++;
        if (zone_dly[3] !== 32'h21C81F1E) begin
            tests_failed++; $display("FAIL sat_zone3_delay got %h exp 21c81f1e", zone_dly[3]);
        end
        tests_run++;
        if (dn !== 261) begin tests_failed++; $display("FAIL sat_done_latency got %0d exp 261", dn); end
        tests_run++;
        if (sen !== 256) begin tests_failed++; $display("FAIL sat_sample_en got %0d exp 256", sen); end
        @(negedge clk);
    endtask

    task automatic test_write_busy();
        int dn, sen, upd, ls, both, errs;
        bit seen_done;
        seen_done = 1'b0; errs = 0;
        start = 1'b1; num_lines = 8'd1;
        for (int n = 1; n <= 300 && !seen_done; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (cfg_err) errs++;
            if (n == 10) begin
                cfg_we = 1'b1; cfg_zone = 2'd1; cfg_ch = 2'd0; cfg_delay = 8'd99;
            end
            if (n == 11) begin
                cfg_we = 1'b0;
                tests_run++;
                if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL busy_cfg_err got %b exp 1", cfg_err); end
            end
            if (n == 12) begin
                tests_run++;
                if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL busy_cfg_err_pulse got %b exp 0", cfg_err); end
            end
            if (done) seen_done = 1'b1;
        end
        tests_run++;
        if (!seen_done || errs != 1) begin
            tests_failed++; $display("FAIL busy_scan_end got done=%b errs=%0d exp done=1 errs=1", seen_done, errs);
        end
        @(negedge clk);
        do_scan(8'd1, dn, sen, upd, ls, both);
        tests_run++;
        if (zone_dly[1] !== 32'h0D0C0B0A) begin
            tests_failed++; $display("FAIL busy_table_unchanged got %h exp 0d0c0b0a", zone_dly[1]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        bit stray_done;
        stray_done = 1'b0;
        start = 1'b1; num_lines = 8'd1;
        for (int n = 1; n <= 162; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        tests_run++;
        if ({sample_en, zone_idx} !== 3'b110) begin
            tests_failed++; $display("FAIL abort_position got en=%b zone=%0d exp en=1 zone=2", sample_en, zone_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if ({busy, sample_en, done} !== 3'b000) begin
            tests_failed++; $display("FAIL abort_idle got busy/en/done=%b exp 000", {busy, sample_en, done});
        end
        tests_run++;
        if (zone_idx !== 2'd2 || delay_o !== 32'h17161514) begin
            tests_failed++; $display("FAIL abort_hold got zone=%0d delay=%h exp zone=2 delay=17161514", zone_idx, delay_o);
        end
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (done || sample_en || busy) stray_done = 1'b1;
        end
        tests_run++;
        if (stray_done) begin tests_failed++; $display("FAIL abort_quiet got activity exp none"); end
        start = 1'b1; num_lines = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({zone_idx, line_idx, line_start, delay_o} !== {2'd0, 8'd0, 1'b1, 32'h03020100}) begin
            tests_failed++;
            $display("FAIL abort_restart got zone=%0d line=%0d ls=%b delay=%h exp 0 0 1 03020100", zone_idx, line_idx, line_start, delay_o);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_zero_lines();
        start = 1'b1; num_lines = 8'd0;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if ({done, busy, sample_en} !== 3'b100) begin
            tests_failed++; $display("FAIL zero_done got done/busy/en=%b exp 100", {done, busy, sample_en});
        end
        @(negedge clk);
        tests_run++;
        if ({done, busy, sample_en} !== 3'b000) begin
            tests_failed++; $display("FAIL zero_after got done/busy/en=%b exp 000", {done, busy, sample_en});
        end
    endtask

    task automatic test_cfg_with_start();
        cfg_we = 1'b1; cfg_zone = 2'd0; cfg_ch = 2'd0; cfg_delay = 8'd77;
        start = 1'b1; num_lines = 8'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        tests_run++;
        if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL start_cfg_err got %b exp 0", cfg_err); end
        @(negedge clk);
        tests_run++;
        if (delay_o !== 32'h0302014D) begin
            tests_failed++; $display("FAIL start_cfg_delay got %h exp 0302014d", delay_o);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        start = 1'b1; num_lines = 8'd2;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if ({busy, done, sample_en, delay_upd, line_start, cfg_err, zone_idx, line_idx, delay_o} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_outputs got flags=%b zone=%0d line=%0d delay=%h exp all 0",
                     {busy, done, sample_en, delay_upd, line_start, cfg_err}, zone_idx, line_idx, delay_o);
        end
        start = 1'b1; num_lines = 8'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({delay_upd, delay_o} !== {1'b1, 32'h0}) begin
            tests_failed++; $display("FAIL reset_mid_table got upd=%b delay=%h exp 1 00000000", delay_upd, delay_o);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        for (int z = 0; z < 4; z++) zone_dly[z] = 32'h0;
        test_reset();
        test_basic_scan();
        test_saturation();
        test_write_busy();
        test_abort();
        test_zero_lines();
        test_cfg_with_start();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
